// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Holds the buffered entry layout, the NOP encoding and the PC step.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Word-align a redirect target.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {PC, instruction} entries.
// Ports: clk_i, rst_i, flush_i, push_i/push_data_i, pop_i, count_o, head_o.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output fetch_entry_t               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  // Guards keep the pointers sane even if a caller misbehaves.
  assign pop_ok  = pop_i & (count_q != '0);
  assign push_ok = push_i &
                   ((count_q != CW'(DEPTH)) | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage controller: issues imem reads, buffers returns, feeds decode.
// Ports: CLK/RST, PC_Cur/PC_Next/PC_En, IMem_*, Redirect_*, ID_Ready, IF_*.
import fetch_pkg::*;

module fetch_controller #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_Cur,
  output logic [31:0] PC_Next,
  output logic        PC_En,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_RData,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        ID_Ready,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          push;
  logic          pop;
  logic          issue;
  logic [OW-1:0] occ;

  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          squash_q, squash_d;

  assign IF_Valid = ~RST & (count != '0);

  // A redirect steals the cycle: no pop.
  assign pop = IF_Valid & ID_Ready & ~Redirect_Valid;

  // Credit: buffered + in-flight - leaving must leave a free slot
  // so every returning word is guaranteed space.
  assign occ = OW'(count) + OW'(inflight_q) - OW'(pop);

  assign issue = ~RST & ~Redirect_Valid &
                 (occ < OW'(DEPTH));

  // Flush on redirect dominates a same-cycle return.
  assign push = inflight_q & ~squash_q & ~Redirect_Valid;

  assign push_data.pc    = inflight_pc_q;
  assign push_data.instr = IMem_RData;

  always_comb begin
    PC_En    = 1'b0;
    PC_Next  = PC_Cur + PC_STEP;
    IMem_Req = 1'b0;
    if (!RST) begin
      if (Redirect_Valid) begin
        PC_En   = 1'b1;
        PC_Next = align_pc(Redirect_Target);
      end else if (issue) begin
        PC_En    = 1'b1;
        IMem_Req = 1'b1;
      end
    end
  end

  assign IMem_Addr = PC_Cur;

  always_comb begin
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    squash_d      = 1'b0;
    if (issue) inflight_pc_d = PC_Cur;
    if (Redirect_Valid) squash_d = inflight_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (Redirect_Valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign IF_Instr = IF_Valid ? head.instr : INSTR_NOP;
  assign IF_PC    = IF_Valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller.
// Drives a PC register and imem model, compares against a queue model.
module tb_fetch_controller;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC_Cur;
  logic [31:0] PC_Next;
  logic        PC_En;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic [31:0] IMem_RData;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        ID_Ready;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;

  fetch_controller #(.DEPTH(DEPTH)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .PC_Cur          (PC_Cur),
    .PC_Next         (PC_Next),
    .PC_En           (PC_En),
    .IMem_Req        (IMem_Req),
    .IMem_Addr       (IMem_Addr),
    .IMem_RData      (IMem_RData),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .ID_Ready        (ID_Ready),
    .IF_Valid        (IF_Valid),
    .IF_Instr        (IF_Instr),
    .IF_PC           (IF_PC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // Environment: PC register and synchronous-read memory.
  logic [31:0] pc_reg = 32'h0;
  logic [31:0] rdata  = 32'h0;
  assign PC_Cur     = pc_reg;
  assign IMem_RData = rdata;

  always @(posedge CLK) begin
    if (RST) pc_reg <= 32'h0;
    else if (PC_En) pc_reg <= PC_Next;
    if (IMem_Req) rdata <= mem_word(IMem_Addr);
  end

  // Reference model: queue of entries visible to decode plus one
  // outstanding fetch.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl = 0;
  bit          m_sq   = 0;
  logic [31:0] m_ipc  = 32'h0;

  bit          p_rst, p_rv, p_pop, p_issue;
  logic [31:0] p_pc;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv,
                      input logic [31:0] rt, input bit rd);
    bit          v;
    bit          pop;
    bit          iss;
    int          occ;
    logic [31:0] e_pc;
    logic [31:0] e_in;
    RST             = r;
    Redirect_Valid  = rv;
    Redirect_Target = rt;
    ID_Ready        = rd;
    #1;
    v    = !r && (mq.size() != 0);
    e_pc = 32'h0;
    e_in = NOP;
    if (v) begin
      e_pc = mq[0].pc;
      e_in = mq[0].instr;
    end
    pop = v && rd && !rv;
    occ = mq.size() + int'(m_infl) - int'(pop);
    iss = !r && !rv && (occ < DEPTH);
    chk("if_valid", 32'(IF_Valid), 32'(v));
    chk("if_pc", IF_PC, e_pc);
    chk("if_instr", IF_Instr, e_in);
    chk("imem_req", 32'(IMem_Req), 32'(iss));
    chk("pc_en", 32'(PC_En), 32'(!r && (iss || rv)));
    chk("imem_addr", IMem_Addr, pc_reg);
    if (!r) begin
      chk("pc_next", PC_Next,
          rv ? (rt & 32'hFFFF_FFFC) : pc_reg + 32'd4);
    end
    p_rst   = r;
    p_rv    = rv;
    p_pop   = pop;
    p_issue = iss;
    p_pc    = pc_reg;
  endtask

  task automatic tick();
    bit   psh;
    ent_t e;
    @(posedge CLK);
    psh = m_infl && !m_sq;
    if (p_rst) begin
      mq.delete();
      m_infl = 0;
      m_sq   = 0;
    end else if (p_rv) begin
      mq.delete();
      m_sq   = m_infl;
      m_infl = 0;
    end else begin
      if (p_pop) void'(mq.pop_front());
      if (psh) begin
        e.pc    = m_ipc;
        e.instr = mem_word(m_ipc);
        mq.push_back(e);
      end
      m_sq   = 0;
      m_infl = p_issue;
      if (p_issue) m_ipc = p_pc;
    end
    @(negedge CLK);
  endtask

  task automatic run(input bit r, input bit rv,
                     input logic [31:0] rt, input bit rd,
                     input int n);
    for (int i = 0; i < n; i++) begin
      step(r, rv, rt, rd);
      tick();
    end
  endtask

  initial begin
    RST             = 1'b1;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
    ID_Ready        = 1'b0;
    @(negedge CLK);

    // Reset, then stall from the start.
    run(1, 0, 32'h0, 0, 2);
    run(0, 0, 32'h0, 0, 6);
    step(0, 0, 32'h0, 0);
    chk("stall_head_pc", IF_PC, 32'h0);
    chk("stall_head_instr", IF_Instr, mem_word(32'h0));
    chk("stall_req", 32'(IMem_Req), 32'h0);
    chk("stall_pc_en", 32'(PC_En), 32'h0);
    tick();
    run(0, 0, 32'h0, 1, 10);

    // Fresh reset: first valid two cycles after first issue.
    run(1, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1);
    chk("first_issue", 32'(IMem_Req), 32'h1);
    tick();
    run(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1);
    chk("first_valid", 32'(IF_Valid), 32'h1);
    chk("first_pc", IF_PC, 32'h0);
    tick();
    run(0, 0, 32'h0, 1, 10);

    // Redirect mid-stream.
    step(0, 1, 32'h100, 1);
    tick();
    step(0, 0, 32'h0, 1);
    chk("redir_gap1", 32'(IF_Valid), 32'h0);
    tick();
    step(0, 0, 32'h0, 1);
    chk("redir_gap2", 32'(IF_Valid), 32'h0);
    tick();
    step(0, 0, 32'h0, 1);
    chk("redir_valid", 32'(IF_Valid), 32'h1);
    chk("redir_pc", IF_PC, 32'h100);
    tick();
    step(0, 0, 32'h0, 1);
    chk("redir_next_pc", IF_PC, 32'h104);
    tick();
    run(0, 0, 32'h0, 1, 3);

    // Unaligned target.
    step(0, 1, 32'h203, 1);
    chk("redir_align", PC_Next, 32'h200);
    tick();
    step(0, 0, 32'h0, 1);
    chk("pc_loaded", IMem_Addr, 32'h200);
    tick();
    run(0, 0, 32'h0, 1, 4);

    // Back-to-back redirects: only the last is fetched.
    run(0, 1, 32'h400, 1, 1);
    run(0, 1, 32'h500, 1, 1);
    run(0, 0, 32'h0, 1, 2);
    step(0, 0, 32'h0, 1);
    chk("b2b_pc", IF_PC, 32'h500);
    tick();
    run(0, 0, 32'h0, 1, 3);

    // PC wrap.
    run(0, 1, 32'hFFFF_FFFC, 1, 1);
    step(0, 0, 32'h0, 1);
    chk("pc_wrap", PC_Next, 32'h0);
    tick();
    run(0, 0, 32'h0, 1, 6);

    // One-cycle reset mid-stream.
    step(1, 0, 32'h0, 1);
    tick();
    step(0, 0, 32'h0, 1);
    chk("rst_clear_valid", 32'(IF_Valid), 32'h0);
    chk("rst_clear_pc", IF_PC, 32'h0);
    tick();
    run(0, 0, 32'h0, 1, 6);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 15) == 0,
           $urandom,
           $urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
